// File: rtl/safe_csr_pkg.sv
// Shared types, register offsets and byte-strobe helpers for the safe-CPU
// wrapper control/status register block.
package safe_csr_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam logic [2:0] OFF_MODE    = 3'd0;
    localparam logic [2:0] OFF_MASTER  = 3'd1;
    localparam logic [2:0] OFF_SYNC    = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_TIMEOUT = 3'd4;
    localparam logic [2:0] OFF_CTRL    = 3'd5;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_DMR    = 2'd1,
        MODE_TMR    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } bar_state_e;

    localparam int unsigned STATUS_DONE = 0;
    localparam int unsigned STATUS_TMO  = 1;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/safe_csr.sv
// The safe-CPU wrapper CSR block is implemented in safe_wrapper_csr.sv.

// File: rtl/safe_csr_barrier.sv
// Per-hart synchronisation barrier: arrival mask, timeout counter and the
// one-cycle release pulse, driven by set/abort strobes from the register decode.
module safe_csr_barrier
    import safe_csr_pkg::*;
#(
    parameter int unsigned NHARTS = 3,
    parameter int unsigned TMO_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NHARTS-1:0] hart_en_i,
    input  logic [TMO_W-1:0]  timeout_i,
    input  logic              set_valid_i,
    input  logic [NHARTS-1:0] set_mask_i,
    input  logic              abort_i,
    output logic [NHARTS-1:0] arrived_o,
    output logic              release_o,
    output logic              done_set_o,
    output logic              tmo_set_o
);

    bar_state_e        state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [NHARTS-1:0] arrived_q, arrived_d;
    logic              release_q;
    logic              complete_s;

    assign complete_s = ((arrived_q & hart_en_i) == hart_en_i);

    // Next-state logic; completion is tested before expiry so it wins a tie.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arrived_d  = set_valid_i ? (arrived_q | set_mask_i) : arrived_q;
        done_set_o = 1'b0;
        tmo_set_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (set_valid_i && ((set_mask_i & hart_en_i) != '0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = timeout_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    arrived_d = '0;
                end else if (complete_s) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    arrived_d = '0;
                    tmo_set_o = 1'b1;
                end else begin
                    cnt_d = cnt_q - TMO_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d    = ST_IDLE;
                arrived_d  = '0;
                done_set_o = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                arrived_d = '0;
            end
        endcase
    end

    // Barrier state, counter, arrival mask and registered release pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            arrived_q <= '0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arrived_q <= arrived_d;
            release_q <= (state_d == ST_RELEASE);
        end
    end

    assign arrived_o = arrived_q;
    assign release_o = release_q;

endmodule

// File: rtl/safe_wrapper_csr.sv
// Reg-bus CSR slave for the safe-CPU wrapper: redundancy mode, master-core
// selection, barrier control and the timeout interrupt.
module safe_wrapper_csr
    import safe_csr_pkg::*;
#(
    parameter int unsigned NHARTS = 3,
    parameter int unsigned TMO_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  reg_req_t          reg_req_i,
    output reg_rsp_t          reg_rsp_o,
    output logic [1:0]        mode_o,
    output logic [1:0]        master_core_o,
    output logic [NHARTS-1:0] hart_en_o,
    output logic              sync_release_o,
    output logic              irq_o
);

    logic [1:0]        mode_q, mode_d;
    logic [1:0]        master_q, master_d;
    logic [TMO_W-1:0]  timeout_q, timeout_d;
    logic              irq_en_q, irq_en_d;
    logic [1:0]        status_q, status_d;
    logic              irq_q, irq_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_ready_q, rsp_ready_d;

    logic              accept_s, wr_s, mapped_s;
    logic [2:0]        off_s;
    logic [31:0]       cur_s, merged_s, wbits_s;
    logic [NHARTS-1:0] hart_en_s, arrived_s;
    logic [2:0]        dmr_peer_s;
    logic              sync_set_s, abort_s, done_set_s, tmo_set_s;
    logic [1:0]        status_clr_s;
    logic              unused_addr_s;

    // A request held across its ready cycle must not execute twice.
    assign accept_s      = reg_req_i.valid & ~rsp_ready_q;
    assign off_s         = reg_req_i.addr[4:2];
    assign mapped_s      = (off_s <= OFF_CTRL);
    assign wr_s          = accept_s & reg_req_i.write & mapped_s;
    assign wbits_s       = reg_req_i.wdata & strb_mask(reg_req_i.wstrb);
    assign merged_s      = apply_strb(cur_s, reg_req_i.wdata, reg_req_i.wstrb);
    assign sync_set_s    = wr_s & (off_s == OFF_SYNC);
    assign abort_s       = wr_s & ((off_s == OFF_MODE) | (off_s == OFF_MASTER));
    assign status_clr_s  = (wr_s && (off_s == OFF_STATUS)) ? wbits_s[1:0] : 2'b00;
    assign unused_addr_s = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0]};
    assign dmr_peer_s    = 3'((32'(master_q) + 32'd1) % NHARTS);

    // Current value of the addressed register, used for reads and strobe merges.
    always_comb begin
        cur_s = 32'd0;
        case (off_s)
            OFF_MODE:    cur_s = {30'd0, mode_q};
            OFF_MASTER:  cur_s = {30'd0, master_q};
            OFF_SYNC:    cur_s = 32'(arrived_s);
            OFF_STATUS:  cur_s = {30'd0, status_q};
            OFF_TIMEOUT: cur_s = 32'(timeout_q);
            OFF_CTRL:    cur_s = {31'd0, irq_en_q};
            default:     cur_s = 32'd0;
        endcase
    end

    // Participating harts; mode 3 is treated as TMR.
    always_comb begin
        hart_en_s = '0;
        case (mode_q)
            MODE_SINGLE: hart_en_s = NHARTS'(1) << master_q;
            MODE_DMR:    hart_en_s = (NHARTS'(1) << master_q) | (NHARTS'(1) << dmr_peer_s);
            default:     hart_en_s = '1;
        endcase
    end

    // Register write decode and response generation.
    always_comb begin
        mode_d    = mode_q;
        master_d  = master_q;
        timeout_d = timeout_q;
        irq_en_d  = irq_en_q;
        if (wr_s) begin
            case (off_s)
                OFF_MODE:    mode_d    = merged_s[1:0];
                OFF_MASTER:  master_d  = merged_s[1:0];
                OFF_TIMEOUT: timeout_d = merged_s[TMO_W-1:0];
                OFF_CTRL:    irq_en_d  = merged_s[0];
                default:     mode_d    = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end
        // Hardware set beats a same-cycle W1C.
        status_d              = status_q & ~status_clr_s;
        status_d[STATUS_DONE] = status_d[STATUS_DONE] | done_set_s;
        status_d[STATUS_TMO]  = status_d[STATUS_TMO] | tmo_set_s;
        irq_d                 = status_d[STATUS_TMO] & irq_en_d;
        rsp_ready_d           = accept_s;
        rsp_error_d           = accept_s & ~mapped_s;
        rsp_rdata_d           = (accept_s && !reg_req_i.write) ? cur_s : 32'd0;
    end

    // Register storage and registered bus response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= 2'd0;
            master_q    <= 2'd0;
            timeout_q   <= '1;
            irq_en_q    <= 1'b0;
            status_q    <= 2'd0;
            irq_q       <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            rsp_ready_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            master_q    <= master_d;
            timeout_q   <= timeout_d;
            irq_en_q    <= irq_en_d;
            status_q    <= status_d;
            irq_q       <= irq_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            rsp_ready_q <= rsp_ready_d;
        end
    end

    safe_csr_barrier #(
        .NHARTS (NHARTS),
        .TMO_W  (TMO_W)
    ) u_barrier (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hart_en_i   (hart_en_s),
        .timeout_i   (timeout_q),
        .set_valid_i (sync_set_s),
        .set_mask_i  (wbits_s[NHARTS-1:0]),
        .abort_i     (abort_s),
        .arrived_o   (arrived_s),
        .release_o   (sync_release_o),
        .done_set_o  (done_set_s),
        .tmo_set_o   (tmo_set_s)
    );

    assign reg_rsp_o     = '{rdata: rsp_rdata_q, error: rsp_error_q, ready: rsp_ready_q};
    assign mode_o        = mode_q;
    assign master_core_o = master_q;
    assign hart_en_o     = hart_en_s;
    assign irq_o         = irq_q;

endmodule
